// File: rtl/fpu_div.sv
// fpu_div: IEEE-754 binary32 restoring divider (27 quotient bits, 5 rounding modes, subnormals flushed).
// Optional exception outputs flag_nv/flag_dz/flag_of/flag_uf are enabled by defining FPU_DIV_EXC_FLAGS_EN.
module fpu_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] operA_float32,
  input  logic [31:0] operB_float32,
  input  logic [2:0]  frm,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        flag_nx
`ifdef FPU_DIV_EXC_FLAGS_EN
  ,
  output logic        flag_nv,
  output logic        flag_dz,
  output logic        flag_of,
  output logic        flag_uf
`endif
);
  typedef enum logic [2:0] {IDLE, CHECK, DIV, ROUND, DONE} state_t;
  state_t state;
  logic [31:0] a, b;
  logic [2:0] rm;
  logic [24:0] rem;
  logic [26:0] q;
  logic [4:0] cnt;
  logic s, za, zb, ia, ib, na, nb, spec, ge, g, st, inc, of, uf, up;
  logic [31:0] spec_res, rnd_res;
  logic [23:0] dvs, man, m24;
  logic signed [9:0] ex, e1, e2;
  logic [2:0] md;
  always_comb begin
    s = a[31] ^ b[31];
    za = a[30:23] == 8'd0;
    zb = b[30:23] == 8'd0;
    ia = a[30:23] == 8'hFF && a[22:0] == 23'd0;
    ib = b[30:23] == 8'hFF && b[22:0] == 23'd0;
    na = a[30:23] == 8'hFF && a[22:0] != 23'd0;
    nb = b[30:23] == 8'hFF && b[22:0] != 23'd0;
    spec = na | nb | za | zb | ia | ib;
    spec_res = (na | nb | (za & zb) | (ia & ib)) ? 32'h7FC00000 :
               (ia | zb) ? {s, 8'hFF, 23'h0} : {s, 31'h0};
    dvs = {1'b1, b[22:0]};
    ge = rem >= {1'b0, dvs};
    ex = $signed({2'b0, a[30:23]}) - $signed({2'b0, b[30:23]}) + 10'sd127;
  end
  // The mantissa ratio lies in (0.5, 2): q[26] tells which binade the quotient landed in.
  always_comb begin
    md = rm > 3'd4 ? 3'd0 : rm;
    man = q[26] ? q[26:3] : q[25:2];
    g = q[26] ? q[2] : q[1];
    st = (q[26] ? |q[1:0] : q[0]) | (|rem);
    e1 = q[26] ? ex : ex - 10'sd1;
    inc = md == 3'd0 ? g & (st | man[0]) :
          md == 3'd2 ? s & (g | st) :
          md == 3'd3 ? ~s & (g | st) :
          md == 3'd4 ? g : 1'b0;
    m24 = man + {23'd0, inc};
    e2 = e1 + $signed({9'd0, ~m24[23]});
    of = e2 >= 10'sd255;
    uf = e2 <= 10'sd0;
    up = md == 3'd0 || md == 3'd4 || (md == 3'd2 && s) || (md == 3'd3 && !s);
    rnd_res = of ? (up ? {s, 8'hFF, 23'h0} : {s, 31'h7F7FFFFF}) :
              uf ? {s, 31'h0} : {s, e2[7:0], m24[22:0]};
  end
`ifdef FPU_DIV_EXC_FLAGS_EN
  logic spec_nv, spec_dz;
  assign spec_nv = (na & ~a[22]) | (nb & ~b[22]) | (za & zb) | (ia & ib);
  assign spec_dz = zb & ~za & ~ia & ~na & ~nb;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      rm <= '0;
      rem <= '0;
      q <= '0;
      cnt <= '0;
      result <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      flag_nx <= 1'b0;
`ifdef FPU_DIV_EXC_FLAGS_EN
      {flag_nv, flag_dz, flag_of, flag_uf} <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a <= operA_float32;
          b <= operB_float32;
          rm <= frm;
          flag_nx <= 1'b0;
          busy <= 1'b1;
          state <= CHECK;
`ifdef FPU_DIV_EXC_FLAGS_EN
          {flag_nv, flag_dz, flag_of, flag_uf} <= '0;
`endif
        end
        CHECK: if (spec) begin
          result <= spec_res;
          state <= DONE;
`ifdef FPU_DIV_EXC_FLAGS_EN
          flag_nv <= spec_nv;
          flag_dz <= spec_dz;
`endif
        end else begin
          rem <= {2'b01, a[22:0]};
          q <= '0;
          cnt <= '0;
          state <= DIV;
        end
        DIV: begin
          rem <= (ge ? rem - {1'b0, dvs} : rem) << 1;
          q <= {q[25:0], ge};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd26) state <= ROUND;
        end
        ROUND: begin
          result <= rnd_res;
          flag_nx <= g | st | of | uf;
          state <= DONE;
`ifdef FPU_DIV_EXC_FLAGS_EN
          flag_of <= of;
          flag_uf <= uf;
`endif
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fpu_div.md
FPU_DIV -- requirements
Module: fpu_div

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: start  input  1  request, sampled only in IDLE.
REQ-004 SHALL have ports: operA_float32  input  32  dividend, IEEE-754 binary32.
REQ-005 SHALL have ports: operB_float32  input  32  divisor, IEEE-754 binary32.
REQ-006 SHALL have ports: frm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE.
REQ-007 SHALL have ports: result  output  32  quotient, registered.
REQ-008 SHALL have ports: done  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports: busy  output  1  high in every state except IDLE.
REQ-010 SHALL have ports: flag_nx  output  1  inexact, valid with done.

Function
REQ-011 SHALL latch operA_float32, operB_float32 and frm on the edge where start=1 in IDLE; later input changes SHALL NOT affect the operation.
REQ-012 SHALL ignore start while busy=1.
REQ-013 SHALL implement FSM IDLE -> CHECK -> DIV -> ROUND -> DONE -> IDLE, with CHECK -> DONE for special operands.
REQ-014 SHALL remain in DIV for exactly 27 cycles, one restoring quotient bit per cycle: remainder starts at mantA, divisor is mantB (both 24-bit, hidden bit 1); each cycle compare, subtract if greater or equal, shift left.
REQ-015 SHALL assert done 30 cycles after the start-sampling edge for normal operands, and 2 cycles after it for special operands; done SHALL be high for exactly one cycle.
REQ-016 SHALL hold result and flags stable from done until the next accepted start.
REQ-017 SHALL set sign = signA XOR signB and biased exponent = expA - expB + 127, computed in at least 10 signed bits.
REQ-018 SHALL normalise: if quotient bit 26 = 1, mantissa = q[26:3], guard = q[2]; otherwise mantissa = q[25:2], guard = q[1], and exponent decrements by 1.
REQ-019 SHALL compute sticky as the OR of the remaining quotient bits and (final remainder != 0).
REQ-020 SHALL round per latched frm using guard, sticky and sign; a mantissa carry-out SHALL increment the exponent.
REQ-021 SHALL set flag_nx = guard | sticky, or 1 on overflow/underflow.
REQ-022 SHALL treat subnormal inputs as signed zero.
REQ-023 SHALL flush a result with exponent <= 0 after rounding to signed zero.
REQ-024 On exponent >= 255 SHALL return ±inf for RNE/RMM and for the rounding direction matching the sign; otherwise ±0x7F7FFFFF magnitude.
REQ-025 Specials SHALL be handled as follows:
- NaN operand, 0/0 or inf/inf -> 0x7FC00000.
- finite/0 -> signed inf.
- 0/nonzero and finite/inf -> signed zero.
- inf/finite -> signed inf.
- flag_nx = 0 for all specials.

Reset
REQ-026 On rst=1 the block SHALL asynchronously go to IDLE and clear result = 0x00000000, done = 0, busy = 0, all flags = 0, iteration counter = 0.
REQ-027 An in-flight operation interrupted by rst SHALL be abandoned with no done pulse; a start on the first edge after rst deasserts SHALL be accepted.

Configuration
REQ-028 With FPU_DIV_EXC_FLAGS_EN defined, SHALL add these outputs, valid with done and cleared on reset and on each accepted start:
- flag_nv (invalid: 0/0, inf/inf, signalling-NaN input).
- flag_dz (finite nonzero / 0).
- flag_of (REQ-024 overflow).
- flag_uf (REQ-023 flush).
REQ-029 Without FPU_DIV_EXC_FLAGS_EN, those ports SHALL NOT exist; datapath, result and latency SHALL be identical.

Verification
REQ-030 0x40F00000 / 0x40400000, frm=000 -> result 0x40200000, flag_nx=0, done exactly 30 cycles after start.
REQ-031 0x3F800000 / 0x40400000 -> frm=000 gives 0x3EAAAAAB; frm=001 gives 0x3EAAAAAA; flag_nx=1 in both cases.
REQ-032 Specials, each with done after 2 cycles:
- 0x3F800000 / 0x00000000 -> 0x7F800000, flag_dz=1.
- 0x00000000 / 0x00000000 -> 0x7FC00000, flag_nv=1.
REQ-033 0x7F7FFFFF / 0x3F000000 -> frm=000 gives 0x7F800000; frm=001 gives 0x7F7FFFFF; flag_nx=1 and flag_of=1 in both cases.
REQ-034 Reset mid-operation:
- Start 0xC0800000 / 0x40000000 and pulse rst at cycle 10 -> no done, outputs zero.
- Restart the same division -> 0xC0000000 after 30 cycles.
REQ-035 Change operands and assert start during DIV -> start ignored, and result matches the originally latched operands.
